branch_predict: RTL and testbench

//  Branch resolution plus dynamic prediction for the 5-stage MIPS pipeline.

---
 rtl/branch_pkg.sv | 19 +
 rtl/sat_ctr.sv | 35 +++
 rtl/branch_predict.sv | 125 ++++++++++++
 tb/tb_branch_predict.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor: condition-code encodings and
// the reset value of the prediction counters.
package branch_pkg;

  localparam logic [2:0] BR_BEQ    = 3'd0;
  localparam logic [2:0] BR_BNE    = 3'd1;
  localparam logic [2:0] BR_BGTZ   = 3'd2;
  localparam logic [2:0] BR_BLEZ   = 3'd3;
  localparam logic [2:0] BR_REGIMM = 3'd4;
  localparam logic [2:0] BR_BLTU   = 3'd5;
  localparam logic [2:0] BR_BGEU   = 3'd6;
  localparam logic [2:0] BR_JUMP   = 3'd7;

  // Weakly not-taken: all ones below the MSB, MSB clear.
  function automatic int weak_nt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_ctr.sv
// Saturating up/down counter with synchronous clear to a parameterised value.
// inc and dec together leave the count unchanged.
module sat_ctr #(
  parameter int            W       = 2,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= CLR_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predict.sv
// Branch resolution, saturating-counter prediction table and branch/miss
// statistics for the 5-stage pipeline.
module branch_predict
  import branch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] FetchPC,
  input  logic              Stall,
  output logic              PredTaken,
  input  logic              ExValid,
  input  logic [ADDR_W-1:0] ExPC,
  input  logic              ExPredTaken,
  input  logic [2:0]        BrCode,
  input  logic              BrRt,
  input  logic              C,
  input  logic              O,
  input  logic              N,
  input  logic              Z,
  output logic              Taken,
  output logic              Mispredict,
  output logic [CNT_W-1:0]  BrCount,
  output logic [CNT_W-1:0]  MissCount
);

  localparam int               DEPTH   = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(weak_nt(CTR_W));

  logic [IDX_W-1:0] fetch_idx, ex_idx;
  logic [CTR_W-1:0] tbl [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic             pred_q, pred_d;

  assign fetch_idx = FetchPC[IDX_W+1:2];
  assign ex_idx    = ExPC[IDX_W+1:2];

  // Byte offset and upper PC bits are deliberately ignored (aliasing allowed);
  // the overflow flag plays no part in any supported condition.
  logic unused_in;
  assign unused_in = ^{FetchPC[ADDR_W-1:IDX_W+2], FetchPC[1:0],
                       ExPC[ADDR_W-1:IDX_W+2], ExPC[1:0], O};

  always_comb begin
    Taken = 1'b0;
    case (BrCode)
      BR_BEQ:    Taken = Z;
      BR_BNE:    Taken = ~Z;
      BR_BGTZ:   Taken = ~Z & ~N;
      BR_BLEZ:   Taken = Z | N;
      BR_REGIMM: Taken = BrRt ? (Z | ~N) : N;
      BR_BLTU:   Taken = ~C;
      BR_BGEU:   Taken = C;
      BR_JUMP:   Taken = 1'b1;
      default:   Taken = 1'b0;
    endcase
  end

  assign Mispredict = ExValid & (Taken != ExPredTaken);

  always_comb begin
    wr_en = '0;
    if (ExValid) begin
      wr_en[ex_idx] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    sat_ctr #(
      .W       (CTR_W),
      .CLR_VAL (CTR_RST)
    ) u_entry (
      .clk_i (CLK),
      .clr_i (RST),
      .inc_i (wr_en[i] & Taken),
      .dec_i (wr_en[i] & ~Taken),
      .cnt_o (tbl[i])
    );
  end

  // Reads the registered entry value, so a same-cycle update is seen one fetch later.
  always_comb begin
    pred_d = pred_q;
    if (!Stall) begin
      pred_d = tbl[fetch_idx][CTR_W-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pred_q <= 1'b0;
    end else begin
      pred_q <= pred_d;
    end
  end

  assign PredTaken = pred_q;

  sat_ctr #(
    .W       (CNT_W),
    .CLR_VAL ('0)
  ) u_br_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .inc_i (ExValid),
    .dec_i (1'b0),
    .cnt_o (BrCount)
  );

  sat_ctr #(
    .W       (CNT_W),
    .CLR_VAL ('0)
  ) u_miss_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .inc_i (Mispredict),
    .dec_i (1'b0),
    .cnt_o (MissCount)
  );

endmodule

// File: tb/tb_branch_predict.sv
// Directed self-checking bench for branch_predict: reset, training and
// saturation, same-cycle read/write, resolution sweep, stall and statistics.
module tb_branch_predict;
  import branch_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] FetchPC = '0;
  logic        Stall = 1'b0;
  logic        PredTaken;
  logic        ExValid = 1'b0;
  logic [31:0] ExPC = '0;
  logic        ExPredTaken = 1'b0;
  logic [2:0]  BrCode = BR_BEQ;
  logic        BrRt = 1'b0;
  logic        C = 1'b0, O = 1'b0, N = 1'b0, Z = 1'b0;
  logic        Taken, Mispredict;
  logic [15:0] BrCount, MissCount;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_br   = '0;
  logic [15:0] exp_miss = '0;

  branch_predict dut (
    .CLK(CLK), .RST(RST), .FetchPC(FetchPC), .Stall(Stall), .PredTaken(PredTaken),
    .ExValid(ExValid), .ExPC(ExPC), .ExPredTaken(ExPredTaken), .BrCode(BrCode),
    .BrRt(BrRt), .C(C), .O(O), .N(N), .Z(Z), .Taken(Taken), .Mispredict(Mispredict),
    .BrCount(BrCount), .MissCount(MissCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic exp, input string name);
    FetchPC = pc;
    tick();
    n_checks++;
    if (PredTaken !== exp) begin
      n_fail++;
      $display("FAIL %s: PredTaken got %b expected %b", name, PredTaken, exp);
    end
  endtask

  task automatic train(input logic [31:0] pc, input logic [2:0] code, input logic z,
                       input logic pt, input logic exp_taken, input string name);
    logic exp_mis;
    ExValid = 1'b1; ExPC = pc; BrCode = code; Z = z; N = 1'b0; C = 1'b0;
    BrRt = 1'b0; ExPredTaken = pt;
    FetchPC = 32'h0000_1000;
    exp_mis = (exp_taken != pt);
    #1;
    n_checks++;
    if (Taken !== exp_taken) begin
      n_fail++;
      $display("FAIL %s taken: got %b expected %b", name, Taken, exp_taken);
    end
    n_checks++;
    if (Mispredict !== exp_mis) begin
      n_fail++;
      $display("FAIL %s mispredict: got %b expected %b", name, Mispredict, exp_mis);
    end
    tick();
    ExValid = 1'b0;
    if (exp_br != 16'hFFFF) exp_br++;
    if (exp_mis && exp_miss != 16'hFFFF) exp_miss++;
    n_checks++;
    if (BrCount !== exp_br || MissCount !== exp_miss) begin
      n_fail++;
      $display("FAIL %s counts: got br=%0d miss=%0d expected br=%0d miss=%0d",
               name, BrCount, MissCount, exp_br, exp_miss);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    n_checks++;
    if (PredTaken !== 1'b0 || BrCount !== 16'h0 || MissCount !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got pred=%b br=%0d miss=%0d expected 0 0 0",
               PredTaken, BrCount, MissCount);
    end
    RST = 1'b0;
    fetch(32'h40, 1'b0, "reset_fetch_0x40");
  endtask

  task automatic test_train_mispredict();
    train(32'h40, BR_BEQ, 1'b1, 1'b0, 1'b1, "beq_first");
    fetch(32'h40, 1'b1, "entry2_pred");
    train(32'h40, BR_BEQ, 1'b1, 1'b1, 1'b1, "beq_second");
    fetch(32'h40, 1'b1, "entry3_pred");
    n_checks++;
    if (MissCount !== 16'd1) begin
      n_fail++;
      $display("FAIL misscount_after_two: got %0d expected 1", MissCount);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) train(32'h80, BR_BEQ, 1'b1, 1'b1, 1'b1, "sat_up");
    fetch(32'h80, 1'b1, "sat_top_pred");
    train(32'h80, BR_BNE, 1'b1, 1'b0, 1'b0, "down_to_2");
    fetch(32'h80, 1'b1, "entry2_pred_down");
    train(32'h80, BR_BNE, 1'b1, 1'b0, 1'b0, "down_to_1");
    fetch(32'h80, 1'b0, "entry1_pred_down");
    train(32'h80, BR_BNE, 1'b1, 1'b0, 1'b0, "down_to_0");
    train(32'h80, BR_BNE, 1'b1, 1'b0, 1'b0, "hold_at_0");
    fetch(32'h80, 1'b0, "entry0_pred");
    // From 0, one taken gives 1 (not-taken), a second gives 2 (taken).
    train(32'h80, BR_BEQ, 1'b1, 1'b0, 1'b1, "up_from_0");
    fetch(32'h80, 1'b0, "entry1_after_floor");
    train(32'h80, BR_BEQ, 1'b1, 1'b0, 1'b1, "up_to_2");
    fetch(32'h80, 1'b1, "entry2_after_floor");
  endtask

  task automatic test_same_cycle();
    train(32'h40, BR_BNE, 1'b1, 1'b1, 1'b0, "prep_3_to_2");
    train(32'h40, BR_BNE, 1'b1, 1'b1, 1'b0, "prep_2_to_1");
    ExValid = 1'b1; ExPC = 32'h40; BrCode = BR_BEQ; Z = 1'b1; ExPredTaken = 1'b0;
    FetchPC = 32'h40;
    tick();
    ExValid = 1'b0;
    if (exp_br != 16'hFFFF) exp_br++;
    if (exp_miss != 16'hFFFF) exp_miss++;
    n_checks++;
    if (PredTaken !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_old: PredTaken got %b expected 0", PredTaken);
    end
    fetch(32'h40, 1'b1, "same_cycle_new");
  endtask

  function automatic logic ref_taken(input logic [2:0] code, input logic rt,
                                     input logic c, input logic n, input logic z);
    case (code)
      BR_BEQ:    return z;
      BR_BNE:    return !z;
      BR_BGTZ:   return !z && !n;
      BR_BLEZ:   return z || n;
      BR_REGIMM: return rt ? (z || !n) : n;
      BR_BLTU:   return !c;
      BR_BGEU:   return c;
      BR_JUMP:   return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic test_resolution();
    logic [4:0] v;
    logic       exp;
    ExValid = 1'b0;
    for (int code = 0; code < 8; code++) begin
      for (int k = 0; k < 16; k++) begin
        v = 5'(k);
        BrCode = 3'(code); BrRt = v[3]; C = v[2]; N = v[1]; Z = v[0]; O = ~v[0];
        ExPredTaken = v[2];
        #1;
        exp = ref_taken(3'(code), v[3], v[2], v[1], v[0]);
        n_checks++;
        if (Taken !== exp || Mispredict !== 1'b0) begin
          n_fail++;
          $display("FAIL resolve code=%0d rt=%b c=%b n=%b z=%b: got taken=%b mis=%b expected %b 0",
                   code, v[3], v[2], v[1], v[0], Taken, Mispredict, exp);
        end
      end
    end
    BrCode = BR_REGIMM; BrRt = 1'b1; N = 1'b1; Z = 1'b0; C = 1'b0;
    #1;
    n_checks++;
    if (Taken !== 1'b0) begin
      n_fail++;
      $display("FAIL regimm_bgez_neg: got %b expected 0", Taken);
    end
    BrCode = BR_BGEU; C = 1'b1; N = 1'b0;
    #1;
    n_checks++;
    if (Taken !== 1'b1) begin
      n_fail++;
      $display("FAIL bgeu_c1: got %b expected 1", Taken);
    end
    tick();
    n_checks++;
    if (BrCount !== exp_br || MissCount !== exp_miss) begin
      n_fail++;
      $display("FAIL counts_idle: got br=%0d miss=%0d expected br=%0d miss=%0d",
               BrCount, MissCount, exp_br, exp_miss);
    end
    O = 1'b0;
  endtask

  task automatic test_stall();
    fetch(32'h40, 1'b1, "stall_pre");
    Stall = 1'b1;
    fetch(32'h100, 1'b1, "stall_hold_a");
    fetch(32'h104, 1'b1, "stall_hold_b");
    Stall = 1'b0;
    fetch(32'h100, 1'b0, "stall_release");
  endtask

  task automatic test_stat_saturation();
    ExValid = 1'b1; ExPC = 32'hC0; BrCode = BR_JUMP; ExPredTaken = 1'b0;
    for (int i = 0; i < 65540; i++) tick();
    ExValid = 1'b0;
    exp_br = 16'hFFFF; exp_miss = 16'hFFFF;
    tick();
    n_checks++;
    if (BrCount !== 16'hFFFF || MissCount !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stat_saturate: got br=%h miss=%h expected ffff ffff", BrCount, MissCount);
    end
    train(32'hC0, BR_JUMP, 1'b0, 1'b0, 1'b1, "stat_stick");
    fetch(32'hC0, 1'b1, "jump_entry_taken");
  endtask

  task automatic test_reset_mid_op();
    RST = 1'b1; ExValid = 1'b1; ExPC = 32'h80; BrCode = BR_JUMP; ExPredTaken = 1'b0;
    FetchPC = 32'hC0;
    tick();
    RST = 1'b0; ExValid = 1'b0;
    exp_br = '0; exp_miss = '0;
    n_checks++;
    if (PredTaken !== 1'b0 || BrCount !== 16'h0 || MissCount !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got pred=%b br=%0d miss=%0d expected 0 0 0",
               PredTaken, BrCount, MissCount);
    end
    fetch(32'hC0, 1'b0, "mid_reset_entry_c0");
    fetch(32'h80, 1'b0, "mid_reset_entry_80");
    fetch(32'h40, 1'b0, "mid_reset_entry_40");
    train(32'h80, BR_BEQ, 1'b1, 1'b0, 1'b1, "post_reset_train");
    fetch(32'h80, 1'b1, "post_reset_entry_80");
  endtask

  initial begin
    test_reset();
    test_train_mispredict();
    test_saturation();
    test_same_cycle();
    test_resolution();
    test_stall();
    test_stat_saturation();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
